// File: rtl/tube_pkg.sv
// Shared types and helpers for the tube display arbiter.
package tube_pkg;

    localparam int NUM_REQ = 3;
    localparam int OWNER_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        OPEN = 2'd2
    } tube_state_e;

    // Round-robin successor of a requester index (wraps after the last requester).
    function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] idx);
        logic [OWNER_W-1:0] nxt;
        if (idx >= OWNER_W'(NUM_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + OWNER_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic [31:0] pick_word(input logic [32*NUM_REQ-1:0] data,
                                              input logic [OWNER_W-1:0] idx);
        logic [31:0] word;
        case (idx)
            2'd0:    word = data[31:0];
            2'd1:    word = data[63:32];
            default: word = data[95:64];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/tube_display_arbiter_if.sv
// Request/display bundle between requesters (master) and the arbiter (slave).
interface tube_display_arbiter_if;
    import tube_pkg::*;

    logic [NUM_REQ-1:0]     req;
    logic [32*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_blink;
    logic                   clear;
    logic [NUM_REQ-1:0]     grant;
    logic [31:0]            disp_num;
    logic                   disp_en;
    logic [OWNER_W-1:0]     disp_owner;
    logic                   busy;

    modport master (
        output req, req_data, req_blink, clear,
        input  grant, disp_num, disp_en, disp_owner, busy
    );

    modport slave (
        input  req, req_data, req_blink, clear,
        output grant, disp_num, disp_en, disp_owner, busy
    );

endinterface

// File: rtl/tube_rr_picker.sv
// Combinational round-robin picker: search starts one past the last owner.
module tube_rr_picker
    import tube_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OWNER_W-1:0] last_owner_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [OWNER_W-1:0] pick_idx_o
);

    logic [OWNER_W-1:0] cand_s;
    logic               found_s;

    // Walk the requesters in rotation order and keep the first one asserted.
    always_comb begin
        pick_o     = '0;
        pick_idx_o = last_owner_i;
        found_s    = 1'b0;
        cand_s     = last_owner_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = next_idx(cand_s);
            if (!found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                pick_o[cand_s] = 1'b1;
                pick_idx_o     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/tube_display_arbiter.sv
// Tube display arbiter: round-robin grant with a minimum hold window.
// Optional blink support is built when TUBE_BLINK_EN is defined.
module tube_display_arbiter
    import tube_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000,
    parameter int BLINK_HALF  = 25000
) (
    input  logic                   clock,
    input  logic                   reset,
    tube_display_arbiter_if.slave  bus
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    tube_state_e        state_q, state_d;
    logic [HCW-1:0]     hold_q, hold_d;
    logic [31:0]        num_q, num_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0] pick_s, grant_s;
    logic [OWNER_W-1:0] pick_idx_s, grant_idx_s;

    tube_rr_picker u_picker (
        .req_i        (bus.req),
        .last_owner_i (owner_q),
        .pick_o       (pick_s),
        .pick_idx_o   (pick_idx_s)
    );

    // Grant selection and next-state logic; clear and reset veto every grant.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = owner_q;
        state_d     = state_q;
        hold_d      = hold_q;
        num_d       = num_q;
        owner_d     = owner_q;

        if (reset || bus.clear) begin
            grant_s = '0;
        end else begin
            case (state_q)
                IDLE, OPEN: begin
                    grant_s     = pick_s;
                    grant_idx_s = pick_idx_s;
                end
                SHOW: begin
                    if (bus.req[owner_q]) begin
                        grant_s[owner_q] = 1'b1;
                    end else begin
                        grant_s = '0;
                    end
                end
                default: grant_s = '0;
            endcase
        end

        if (bus.clear) begin
            state_d = IDLE;
            hold_d  = '0;
        end else if (|grant_s) begin
            state_d = SHOW;
            hold_d  = HOLD_LOAD;
            num_d   = pick_word(bus.req_data, grant_idx_s);
            owner_d = grant_idx_s;
        end else if (state_q == SHOW) begin
            if (hold_q == '0) begin
                state_d = OPEN;
            end else begin
                hold_d = hold_q - HCW'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // Main state registers; owner resets to the last index so requester 0 wins first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            num_q   <= 32'h0000_0000;
            owner_q <= OWNER_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            num_q   <= num_d;
            owner_q <= owner_d;
        end
    end

`ifdef TUBE_BLINK_EN
    localparam int BCW = $clog2(BLINK_HALF + 1);

    logic           blink_q, blink_d;
    logic           phase_q, phase_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;

    // Blink timer restarts lit at every grant and toggles each BLINK_HALF cycles.
    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        if (bus.clear) begin
            bcnt_d = '0;
        end else if (|grant_s) begin
            blink_d = |(bus.req_blink & grant_s);
            phase_d = 1'b1;
            bcnt_d  = '0;
        end else if ((state_q != IDLE) && blink_q) begin
            if (bcnt_q == BCW'(BLINK_HALF - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BCW'(1);
            end
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Blink state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_q <= 1'b0;
            phase_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign bus.disp_en = (state_q != IDLE) && (!blink_q || phase_q);
`else
    logic unused_blink_s;
    assign unused_blink_s = ^bus.req_blink;
    assign bus.disp_en    = (state_q != IDLE);
`endif

    assign bus.grant      = grant_s;
    assign bus.disp_num   = num_q;
    assign bus.disp_owner = owner_q;
    assign bus.busy       = (state_q == SHOW);

endmodule
